local_mem_bank_ctrl: RTL and testbench
======================================

// Module: local_mem_bank_ctrl
// PURPOSE
//  - One local-memory bank behind one slave port of the compute-unit local-memory interleaved crossbar.
//  - Accepts OBI requests carrying a bank-local byte address and drives a single-port word SRAM.
//  - Returns one OBI response per granted request (reads and writes), one cycle after the grant.
//  - Keeps saturating read/write access counters for profiling.
// PARAMETERS
//  - BANK_SIZE  32'h00008000  bank capacity in bytes; power of two, >= 8
//  - CNT_WIDTH  32            width of each access counter
//  - BANK_WORDS (localparam)  BANK_SIZE/4
//  - WADDR_W    (localparam)  $clog2(BANK_WORDS)
// PORTS
//  - clk_i        in   1     clock
//  - rst_i        in   1     synchronous reset, active-high
//  - bank_req     in   obi   obi_req_if.slave: req, we, be[3:0], addr[31:0], wdata[31:0] in; gnt out
//  - bank_rsp     out  obi   obi_rsp_if.master: rdata[31:0], rvalid out
//  - clr_cnt_i    in   1     synchronous clear of both access counters
//  - init_done_o  out  1     bank is accepting requests
//  - rd_cnt_o     out  CNT_WIDTH  granted reads, saturating
//  - wr_cnt_o     out  CNT_WIDTH  granted writes, saturating
// BEHAVIOUR
//  - Reset values: rvalid=0, rdata=0, rd_cnt_o=0, wr_cnt_o=0, FSM=ST_INIT (macro) or ST_RUN.
//  - Reset values, continued: gnt=0 in every cycle rst_i=1.
//  - Word index: addr[WADDR_W+1:2]. Address bits above this and addr[1:0] are ignored, so addresses alias modulo BANK_SIZE.
//  - Grant: gnt = req & (state==ST_RUN) & !rst_i. Combinational, same cycle. No request buffering; one access per cycle.
//  - Write on grant: the SRAM updates only the bytes whose be bit is set.
//  - Read on grant: the SRAM is read at the word index.
//  - Response: the cycle after a grant, rvalid=1.
//    - Read: rdata = word contents after all earlier writes.
//    - Write: rdata = 32'h0.
//    - Without a grant in the previous cycle: rvalid=0 and rdata=0.
//  - Back-to-back: a write in cycle N followed by a read of the same word in cycle N+1 returns the new data in cycle N+2.
//  - Counters:
//    - +1 on each granted read (we=0) or write (we=1).
//    - Each counter holds at all-ones; no wrap.
//    - clr_cnt_i has priority over an increment in the same cycle; the counters read 0 the next cycle.
//  - FSM (local_mem_pkg::bank_state_e):
//    - ST_INIT: writes zero to every word, then moves to ST_RUN.
//    - ST_RUN: terminal state.
//  - Reset mid-operation: the next cycle is the reset state; the in-flight response is dropped (rvalid=0).
// CONFIGURATION
//  - Macro LOCAL_MEM_ZERO_INIT_EN.
//  - Defined:
//    - Reset enters ST_INIT; the init counter starts at 0.
//    - Each cycle in ST_INIT writes 32'h0 with be=4'hF to word init_cnt, then increments init_cnt.
//    - After writing word BANK_WORDS-1, the next state is ST_RUN. ST_INIT lasts exactly BANK_WORDS cycles.
//    - gnt=0 and init_done_o=0 throughout ST_INIT; init_done_o=1 from the first ST_RUN cycle.
//    - Reset during ST_INIT restarts the sweep at word 0.
//  - Undefined:
//    - No init counter and no ST_INIT; reset enters ST_RUN.
//    - init_done_o=0 while rst_i=1 and 1 otherwise.
//    - SRAM contents after reset are undefined (X in simulation).
// STRUCTURE
//  - local_mem_pkg:
//    - bank_state_e {ST_INIT, ST_RUN}
//    - OBI_DATA_W=32, OBI_BE_W=4
//    - function bank_words(bytes)
//  - Sub-module local_mem_sram #(NUM_WORDS, DATA_W=32):
//    - behavioural 1RW SRAM: req, we, be, waddr, wdata -> rdata, one-cycle read latency
//    - no reset on the array
//  - Top level holds: FSM, init counter, grant logic, rvalid/write-flag pipeline register, counters.
//  - Top level muxes SRAM port inputs between the init sweep and the OBI request.
// TESTING
//  - All tests use BANK_SIZE=32'h40 (16 words) unless noted.
//  - Zero-init (macro on):
//    - Release reset, hold req=1 -> gnt=0 for 16 cycles, then init_done_o=1 and gnt=1.
//    - Read addr 0x14 -> rdata 32'h0.
//  - Write/read:
//    - Write 32'hDEADBEEF, addr 0x10, be=4'hF -> gnt same cycle; next cycle rvalid=1, rdata=0.
//    - Read addr 0x50 (alias of 0x10) -> rdata 32'hDEADBEEF.
//  - Byte enables:
//    - Over 32'hDEADBEEF, write 32'h11223344 with be=4'b0101, then read -> 32'hDE22BE44.
//  - Streaming:
//    - req held 8 cycles, alternating W(addr 0x8, data=i)/R(addr 0x8) -> 8 grants, 8 consecutive rvalid pulses.
//    - Each read returns the preceding write's data.
//  - Counters (CNT_WIDTH=4):
//    - 20 reads and 3 writes -> rd_cnt_o=15, wr_cnt_o=3.
//    - clr_cnt_i with a simultaneous granted read -> both counters 0.
//  - Reset mid-init (macro on):
//    - rst_i for one cycle at init word 7 -> init_done_o rises exactly 16 cycles after reset release.
//    - Pending rvalid is suppressed.

Source files
------------

// File: rtl/local_mem_pkg.sv
// Shared types and helpers for the local-memory bank controller.
// The optional zero-init sweep is selected with LOCAL_MEM_ZERO_INIT_EN.
package local_mem_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } bank_state_e;

   localparam int OBI_DATA_W = 32;
   localparam int OBI_BE_W   = 4;

   function automatic int unsigned bank_words(input int unsigned bytes);
      return bytes / 4;
   endfunction

endpackage

// File: rtl/obi_if.sv
// OBI request and response channel bundles used between the crossbar and a bank.
interface obi_req_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;

   modport master (output req, we, be, addr, wdata, input gnt);
   modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (output rdata, rvalid);
   modport slave  (input rdata, rvalid);
endinterface

// File: rtl/local_mem_sram.sv
// Behavioural single-port word SRAM with byte write enables and one-cycle read latency.
// The array has no reset, so unwritten words read as X in simulation.
module local_mem_sram #(
   parameter  int NUM_WORDS = 16,
   parameter  int DATA_W    = 32,
   localparam int ADDR_W    = $clog2(NUM_WORDS),
   localparam int BE_W      = DATA_W / 8
) (
   input  logic              clk,
   input  logic              req,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [NUM_WORDS];

   // rdata only changes on a read so it keeps the last read word otherwise
   always_ff @(posedge clk) begin
      if (req) begin
         if (we) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be[b]) begin
                  mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end else begin
            rdata <= mem[waddr];
         end
      end
   end

endmodule

// File: rtl/local_mem_bank_ctrl.sv
// One local-memory bank behind an OBI slave port, with saturating access counters.
// Define LOCAL_MEM_ZERO_INIT_EN to zero the whole bank after reset before accepting requests.
module local_mem_bank_ctrl
   import local_mem_pkg::*;
#(
   parameter logic [31:0] BANK_SIZE = 32'h00008000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   obi_req_if.slave             bank_req,
   obi_rsp_if.master            bank_rsp,
   input  logic                 clr_cnt_i,
   output logic                 init_done_o,
   output logic [CNT_WIDTH-1:0] rd_cnt_o,
   output logic [CNT_WIDTH-1:0] wr_cnt_o
);

   localparam int unsigned BANK_WORDS = bank_words(BANK_SIZE);
   localparam int          WADDR_W    = $clog2(BANK_WORDS);

`ifdef LOCAL_MEM_ZERO_INIT_EN
   localparam bank_state_e RESET_STATE = ST_INIT;
`else
   localparam bank_state_e RESET_STATE = ST_RUN;
`endif

   bank_state_e             state_q;
   bank_state_e             state_d;
   logic                    gnt;
   logic                    init_last;
   logic [WADDR_W-1:0]      req_waddr;
   logic                    rvalid_q;
   logic                    wr_q;
   logic [CNT_WIDTH-1:0]    rd_cnt_q;
   logic [CNT_WIDTH-1:0]    wr_cnt_q;

   logic                    sram_req;
   logic                    sram_we;
   logic [OBI_BE_W-1:0]     sram_be;
   logic [WADDR_W-1:0]      sram_waddr;
   logic [OBI_DATA_W-1:0]   sram_wdata;
   logic [OBI_DATA_W-1:0]   sram_rdata;

   // Addresses alias modulo the bank size; the dropped bits are deliberately ignored
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bank_req.addr[31:WADDR_W+2], bank_req.addr[1:0]};

   assign req_waddr    = bank_req.addr[WADDR_W+1:2];
   assign gnt          = bank_req.req && (state_q == ST_RUN) && !rst_i;
   assign bank_req.gnt = gnt;
   assign init_done_o  = (state_q == ST_RUN) && !rst_i;

`ifdef LOCAL_MEM_ZERO_INIT_EN
   logic [WADDR_W-1:0] init_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         init_cnt_q <= '0;
      end else if (state_q == ST_INIT) begin
         init_cnt_q <= init_cnt_q + 1'b1;
      end
   end

   assign init_last = (init_cnt_q == WADDR_W'(BANK_WORDS - 1));
`else
   assign init_last = 1'b1;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (init_last) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = RESET_STATE;
      endcase
   end

   // The init sweep owns the SRAM port while it runs; no grants can occur then
   always_comb begin
      sram_req   = gnt;
      sram_we    = bank_req.we;
      sram_be    = bank_req.be;
      sram_waddr = req_waddr;
      sram_wdata = bank_req.wdata;
`ifdef LOCAL_MEM_ZERO_INIT_EN
      if (state_q == ST_INIT) begin
         sram_req   = 1'b1;
         sram_we    = 1'b1;
         sram_be    = '1;
         sram_waddr = init_cnt_q;
         sram_wdata = '0;
      end
`endif
   end

   local_mem_sram #(
      .NUM_WORDS (BANK_WORDS),
      .DATA_W    (OBI_DATA_W)
   ) u_sram (
      .clk   (clk_i),
      .req   (sram_req),
      .we    (sram_we),
      .be    (sram_be),
      .waddr (sram_waddr),
      .wdata (sram_wdata),
      .rdata (sram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         rvalid_q <= gnt;
         wr_q     <= gnt && bank_req.we;
      end
   end

   // The SRAM output register holds stale data between reads, so gate it to zero
   assign bank_rsp.rvalid = rvalid_q;
   assign bank_rsp.rdata  = (rvalid_q && !wr_q) ? sram_rdata : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_cnt_i) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (gnt && !bank_req.we && !(&rd_cnt_q)) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
         end
         if (gnt && bank_req.we && !(&wr_cnt_q)) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
         end
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_local_mem_bank_ctrl.sv
// Directed self-checking bench for local_mem_bank_ctrl on a 16-word bank with 4-bit counters.
// Zero-init checks are compiled in when LOCAL_MEM_ZERO_INIT_EN is defined.
module tb_local_mem_bank_ctrl;

   localparam logic [31:0] BANK_SIZE = 32'h40;
   localparam int          CNT_WIDTH = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 clr_cnt_i;
   logic                 init_done_o;
   logic [CNT_WIDTH-1:0] rd_cnt_o;
   logic [CNT_WIDTH-1:0] wr_cnt_o;

   obi_req_if bank_req ();
   obi_rsp_if bank_rsp ();

   int vectors_applied = 0;
   int miscompares     = 0;

   local_mem_bank_ctrl #(
      .BANK_SIZE (BANK_SIZE),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bank_req    (bank_req),
      .bank_rsp    (bank_rsp),
      .clr_cnt_i   (clr_cnt_i),
      .init_done_o (init_done_o),
      .rd_cnt_o    (rd_cnt_o),
      .wr_cnt_o    (wr_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not reach the end of the directed sequence");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors_applied++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one request, checks the same-cycle grant, then the response one cycle later
   task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic exp_gnt, input logic [31:0] exp_rdata);
      bank_req.req   = 1'b1;
      bank_req.we    = we;
      bank_req.addr  = addr;
      bank_req.wdata = wdata;
      bank_req.be    = be;
      #1;
      checkOutput({tag, ".gnt"}, 32'(bank_req.gnt), 32'(exp_gnt));
      tick();
      checkOutput({tag, ".rvalid"}, 32'(bank_rsp.rvalid), 32'(exp_gnt));
      checkOutput({tag, ".rdata"}, bank_rsp.rdata, (exp_gnt && !we) ? exp_rdata : 32'h0);
   endtask

   task automatic idleCycle(input string tag);
      bank_req.req = 1'b0;
      #1;
      checkOutput({tag, ".gnt"}, 32'(bank_req.gnt), 32'h0);
      tick();
      checkOutput({tag, ".rvalid"}, 32'(bank_rsp.rvalid), 32'h0);
      checkOutput({tag, ".rdata"}, bank_rsp.rdata, 32'h0);
   endtask

`ifdef LOCAL_MEM_ZERO_INIT_EN
   task automatic initSweepCheck(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         #1;
         checkOutput({tag, ".gnt"}, 32'(bank_req.gnt), 32'h0);
         checkOutput({tag, ".init_done"}, 32'(init_done_o), 32'h0);
         checkOutput({tag, ".rvalid"}, 32'(bank_rsp.rvalid), 32'h0);
         tick();
      end
   endtask
`endif

   initial begin
      rst_i          = 1'b1;
      clr_cnt_i      = 1'b0;
      bank_req.req   = 1'b1;
      bank_req.we    = 1'b0;
      bank_req.be    = 4'hF;
      bank_req.addr  = 32'h14;
      bank_req.wdata = 32'h0;
      tick();
      tick();

      checkOutput("reset.gnt", 32'(bank_req.gnt), 32'h0);
      checkOutput("reset.rvalid", 32'(bank_rsp.rvalid), 32'h0);
      checkOutput("reset.rdata", bank_rsp.rdata, 32'h0);
      checkOutput("reset.rd_cnt", 32'(rd_cnt_o), 32'h0);
      checkOutput("reset.wr_cnt", 32'(wr_cnt_o), 32'h0);
      checkOutput("reset.init_done", 32'(init_done_o), 32'h0);

      rst_i = 1'b0;
`ifdef LOCAL_MEM_ZERO_INIT_EN
      initSweepCheck("init", 16);
      #1;
      checkOutput("init.done_rise", 32'(init_done_o), 32'h1);
      applyStimulus("zero_init_rd", 1'b0, 32'h14, 32'h0, 4'hF, 1'b1, 32'h0);
`else
      #1;
      checkOutput("run.init_done", 32'(init_done_o), 32'h1);
`endif

      applyStimulus("wr_beef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
      applyStimulus("rd_alias", 1'b0, 32'h50, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF);
      applyStimulus("wr_be", 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1, 32'h0);
      applyStimulus("rd_be", 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDE22BE44);
      idleCycle("idle0");

      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            applyStimulus($sformatf("stream_wr%0d", i), 1'b1, 32'h8, 32'(i), 4'hF, 1'b1, 32'h0);
         end else begin
            applyStimulus($sformatf("stream_rd%0d", i), 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 32'(i - 1));
         end
      end

`ifdef LOCAL_MEM_ZERO_INIT_EN
      checkOutput("stream.rd_cnt", 32'(rd_cnt_o), 32'd7);
`else
      checkOutput("stream.rd_cnt", 32'(rd_cnt_o), 32'd6);
`endif
      checkOutput("stream.wr_cnt", 32'(wr_cnt_o), 32'd6);

      clr_cnt_i = 1'b1;
      idleCycle("clr_idle");
      clr_cnt_i = 1'b0;
      checkOutput("clr.rd_cnt", 32'(rd_cnt_o), 32'h0);
      checkOutput("clr.wr_cnt", 32'(wr_cnt_o), 32'h0);

      applyStimulus("cnt_wr0", 1'b1, 32'h0, 32'hAAAA5555, 4'hF, 1'b1, 32'h0);
      applyStimulus("cnt_wr1", 1'b1, 32'h4, 32'h0F0F0F0F, 4'hF, 1'b1, 32'h0);
      applyStimulus("cnt_wr2", 1'b1, 32'hC, 32'hC3C3C3C3, 4'hF, 1'b1, 32'h0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("cnt_rd%0d", i), 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'hAAAA5555);
         if (i == 14) begin
            checkOutput("cnt.rd_reach_max", 32'(rd_cnt_o), 32'd15);
         end
      end
      checkOutput("cnt.rd_saturated", 32'(rd_cnt_o), 32'd15);
      checkOutput("cnt.wr_count", 32'(wr_cnt_o), 32'd3);

      clr_cnt_i = 1'b1;
      applyStimulus("clr_with_rd", 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'hAAAA5555);
      clr_cnt_i = 1'b0;
      checkOutput("clr_rd.rd_cnt", 32'(rd_cnt_o), 32'h0);
      checkOutput("clr_rd.wr_cnt", 32'(wr_cnt_o), 32'h0);

      // A read is granted, then reset lands while its response is on the bus
      bank_req.req  = 1'b1;
      bank_req.we   = 1'b0;
      bank_req.addr = 32'h0;
      #1;
      checkOutput("pre_rst.gnt", 32'(bank_req.gnt), 32'h1);
      tick();
      rst_i = 1'b1;
      #1;
      checkOutput("mid_rst.gnt", 32'(bank_req.gnt), 32'h0);
      tick();
      rst_i = 1'b0;
      checkOutput("post_rst.rvalid", 32'(bank_rsp.rvalid), 32'h0);
      checkOutput("post_rst.rdata", bank_rsp.rdata, 32'h0);
      checkOutput("post_rst.rd_cnt", 32'(rd_cnt_o), 32'h0);

`ifdef LOCAL_MEM_ZERO_INIT_EN
      initSweepCheck("init2_part", 7);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      initSweepCheck("init3", 16);
      #1;
      checkOutput("init3.done_rise", 32'(init_done_o), 32'h1);
      applyStimulus("init3_rd0", 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h0);
      applyStimulus("init3_rdC", 1'b0, 32'hC, 32'h0, 4'hF, 1'b1, 32'h0);
`else
      bank_req.req = 1'b0;
      #1;
      checkOutput("post_rst.init_done", 32'(init_done_o), 32'h1);
      applyStimulus("post_rst_wr", 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b1, 32'h0);
      applyStimulus("post_rst_rd", 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 32'h12345678);
`endif
      idleCycle("idle_end");

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
